debounce_filter: RTL and testbench

//  Front-end conditioner for the push-buttons, one stage upstream of the edge/one-shot FSM.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 73 +++++++
 rtl/debounce_filter.sv | 50 +++++
 tb/tb_debounce_filter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button debounce slice.
// Channel state encoding and counter sizing live here.
package debounce_pkg;

  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_CONFIRM = 1'b1;

  localparam int DEF_N_BTN          = 5;
  localparam int DEF_TICK_DIV       = 100000;
  localparam int DEF_STABLE_SAMPLES = 10;

  // Bits needed to hold the values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-FF synchroniser, then a tick-sampled
// confirm FSM that accepts a new level after enough agreeing ticks.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic raw,
  output logic stable,
  output logic pending
);

  localparam int CW = clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          s1;
  logic          s2;
  logic          state;
  logic [CW-1:0] cnt;
  logic          differs;

  assign differs = (s2 != stable);
  assign pending = (state == ST_CONFIRM);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= ST_STABLE;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (sample_tick) begin
        unique case (1'b1)
          (state == ST_STABLE): begin
            if (!differs) begin
              cnt <= '0;
            end else if (STABLE_SAMPLES == 1) begin
              stable <= s2;
            end else begin
              cnt   <= ONE;
              state <= ST_CONFIRM;
            end
          end
          (state == ST_CONFIRM): begin
            if (!differs) begin
              // candidate fell back: glitch
              cnt   <= '0;
              state <= ST_STABLE;
            end else if (cnt == LAST) begin
              stable <= s2;
              cnt    <= '0;
              state  <= ST_STABLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_STABLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// Push-button conditioner: shared sample-tick prescaler
// feeding N_BTN independent debounce lanes.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int N_BTN          = DEF_N_BTN,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_pending,
  output logic             sample_tick
);

  localparam int PW = clog2(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PONE  = PW'(1);

  logic [PW-1:0] pcnt;

  // Strobe decodes straight off the counter register.
  assign sample_tick = (pcnt == PLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt == PLAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PONE;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sample_tick(sample_tick),
      .raw        (btn_raw[i]),
      .stable     (btn_stable[i]),
      .pending    (btn_pending[i])
    );
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: directed step table plus
// randomized bouncing checked against a tick/run-length model.
module tb_debounce_filter;

  localparam int TD = 4;
  localparam int SS = 3;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_stable;
  logic [NB-1:0] btn_pending;
  logic          sample_tick;

  always #5 clk = ~clk;

  debounce_filter #(
    .N_BTN(NB),
    .TICK_DIV(TD),
    .STABLE_SAMPLES(SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_stable (btn_stable),
    .btn_pending(btn_pending),
    .sample_tick(sample_tick)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference: cycle count since reset gives tick phase, raw history
  // gives the 2-clk delayed sample, and a run length of consecutive
  // disagreeing ticks decides when a level is accepted.
  int            m_cyc;
  logic [NB-1:0] m_hist [2];
  logic [NB-1:0] m_stable;
  int            m_run [NB];

  always @(posedge clk) begin
    if (reset) begin
      m_cyc     = 0;
      m_hist[0] = '0;
      m_hist[1] = '0;
      m_stable  = '0;
      for (int c = 0; c < NB; c++) m_run[c] = 0;
    end else begin
      if (m_cyc % TD == TD - 1) begin
        for (int c = 0; c < NB; c++) begin
          if (m_hist[1][c] != m_stable[c]) begin
            m_run[c]++;
            if (m_run[c] == SS) begin
              m_stable[c] = m_hist[1][c];
              m_run[c]    = 0;
            end
          end else begin
            m_run[c] = 0;
          end
        end
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = btn_raw;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NB-1:0] ep;
      for (int c = 0; c < NB; c++) ep[c] = (m_run[c] > 0);
      check("model_stable", 8'(btn_stable), 8'(m_stable));
      check("model_pending", 8'(btn_pending), 8'(ep));
      check("model_tick", 8'(sample_tick), 8'(m_cyc % TD == TD - 1));
    end
  end

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw;
    int            n;
    logic [NB-1:0] st;
    logic [NB-1:0] pd;
    logic          tk;
  } vec_t;

  vec_t tbl [20];
  int   hold [NB];

  initial begin
    // reset held with raw=11, then clean press ch0
    tbl[0]  = '{1'b1, 2'b11, 4,  2'b00, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 3,  2'b00, 2'b00, 1'b1};
    tbl[2]  = '{1'b0, 2'b01, 1,  2'b00, 2'b01, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 4,  2'b00, 2'b01, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 3,  2'b00, 2'b01, 1'b1};
    tbl[5]  = '{1'b0, 2'b01, 1,  2'b01, 2'b00, 1'b0};
    // release ch0
    tbl[6]  = '{1'b0, 2'b00, 3,  2'b01, 2'b00, 1'b1};
    tbl[7]  = '{1'b0, 2'b00, 1,  2'b01, 2'b01, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 8,  2'b00, 2'b00, 1'b0};
    // 6-clk glitch on ch0
    tbl[9]  = '{1'b0, 2'b01, 6,  2'b00, 2'b01, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 6,  2'b00, 2'b00, 1'b0};
    // reset mid-confirm
    tbl[11] = '{1'b0, 2'b01, 8,  2'b00, 2'b01, 1'b0};
    tbl[12] = '{1'b1, 2'b01, 1,  2'b00, 2'b00, 1'b0};
    tbl[13] = '{1'b0, 2'b01, 11, 2'b00, 2'b01, 1'b1};
    tbl[14] = '{1'b0, 2'b01, 1,  2'b01, 2'b00, 1'b0};
    // ch0 press while ch1 glitches for one tick
    tbl[15] = '{1'b1, 2'b00, 2,  2'b00, 2'b00, 1'b0};
    tbl[16] = '{1'b0, 2'b11, 4,  2'b00, 2'b11, 1'b0};
    tbl[17] = '{1'b0, 2'b01, 4,  2'b00, 2'b01, 1'b0};
    tbl[18] = '{1'b0, 2'b01, 4,  2'b01, 2'b00, 1'b0};
    tbl[19] = '{1'b0, 2'b01, 8,  2'b01, 2'b00, 1'b0};

    reset   = 1'b1;
    btn_raw = 2'b11;
    @(negedge clk);
    chk_en = 1'b1;

    for (int i = 0; i < 20; i++) begin
      reset   = tbl[i].rst;
      btn_raw = tbl[i].raw;
      repeat (tbl[i].n) @(negedge clk);
      check($sformatf("step%0d_stable", i), 8'(btn_stable), 8'(tbl[i].st));
      check($sformatf("step%0d_pending", i), 8'(btn_pending), 8'(tbl[i].pd));
      check($sformatf("step%0d_tick", i), 8'(sample_tick), 8'(tbl[i].tk));
    end

    // tick period and width right after a reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("period_clk%0d", k), 8'(sample_tick),
            8'(k % TD == TD - 1));
    end

    // bouncing buttons with a mix of short and long holds
    for (int c = 0; c < NB; c++) hold[c] = 0;
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NB; c++) begin
        if (hold[c] == 0) begin
          btn_raw[c] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 2) == 0) hold[c] = $urandom_range(10, 40);
          else hold[c] = $urandom_range(1, 8);
        end else begin
          hold[c]--;
        end
      end
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
